dram_access_unit: RTL

- Memory-side responder for the core's data-memory requests; consumes the decoder's write-enable, sub-word type and sign-control signals.
- Load path: reads a word from a word-addressed synchronous-read DRAM, then extracts and sign/zero-extends the byte, half or word.
- Store path: word stores are written directly. Byte and half stores use a 2-cycle read-modify-write, which matches the decoder's two-cycle sub-word store split.
- Sits between the EX/MEM stage and the DRAM macro.

---
 rtl/dram_access_unit_pkg.sv | 28 ++
 rtl/dram_lane_merge.sv | 41 ++++
 rtl/dram_access_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dram_access_unit_pkg.sv
// rtl/dram_access_unit_pkg.sv - shared codes, state encoding and alignment helpers for the DRAM access unit
package dram_access_unit_pkg;

  localparam logic [1:0] DRAM_EX_WORD = 2'b00;
  localparam logic [1:0] DRAM_EX_BYTE = 2'b01;
  localparam logic [1:0] DRAM_EX_HALF = 2'b10;

  localparam logic DRAM_WRITE = 1'b1;
  localparam logic DRAM_READ  = 1'b0;

  typedef enum logic [1:0] {
    DAU_IDLE      = 2'd0,
    DAU_LOAD_WAIT = 2'd1,
    DAU_RMW_MERGE = 2'd2
  } dau_state_t;

  // ex_type 11 has no sub-word meaning and is handled as a full word
  function automatic logic is_word(input logic [1:0] ex_type);
    return (ex_type != DRAM_EX_BYTE) && (ex_type != DRAM_EX_HALF);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] ex_type, input logic [1:0] offset);
    if (ex_type == DRAM_EX_HALF) return offset[0];
    if (is_word(ex_type))        return offset != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/dram_lane_merge.sv
// rtl/dram_lane_merge.sv - combinational lane extract/extend for loads and lane replace for sub-word stores
module dram_lane_merge
  import dram_access_unit_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  ex_type,
  input  logic        ld_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = old_word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? old_word[31:16] : old_word[15:0];
    ld_data   = old_word;
    merged    = new_data;
    case (ex_type)
      DRAM_EX_BYTE: begin
        ld_data = ld_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        merged  = old_word;
        merged[{offset, 3'b000} +: 8] = new_data[7:0];
      end
      DRAM_EX_HALF: begin
        ld_data = ld_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        // halves are aligned, so only offset[1] picks the lane pair
        merged  = offset[1] ? {new_data[15:0], old_word[15:0]}
                            : {old_word[31:16], new_data[15:0]};
      end
      default: begin
        ld_data = old_word;
        merged  = new_data;
      end
    endcase
  end

endmodule

// File: rtl/dram_access_unit.sv
// rtl/dram_access_unit.sv - data-memory responder: loads with extension, word stores, sub-word read-modify-write
module dram_access_unit
  import dram_access_unit_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        ex_type,
  input  logic              ld_unsigned,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  dau_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        off_q;
  logic [1:0]        type_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              capture;

  logic [ADDR_W-1:0] req_idx;
  logic [1:0]        req_off;
  logic [31:0]       ld_ext;
  logic [31:0]       merged;
  logic              unused_addr_hi;

  assign req_idx        = addr[ADDR_W+1:2];
  assign req_off        = addr[1:0];
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Busy states work only from latched copies; the core holds its inputs under stall anyway
  dram_lane_merge u_lane_merge (
    .offset      (off_q),
    .ex_type     (type_q),
    .ld_unsigned (uns_q),
    .old_word    (mem_rdata),
    .new_data    (wdata_q),
    .ld_data     (ld_ext),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DAU_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      type_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        idx_q   <= req_idx;
        off_q   <= req_off;
        type_q  <= ex_type;
        uns_q   <= ld_unsigned;
        wdata_q <= wdata;
      end
      if (state_q == DAU_LOAD_WAIT) rdata_q <= ld_ext;
    end
  end

  // The load result shows up alongside done and is then held until the next load
  assign rdata = (state_q == DAU_LOAD_WAIT) ? ld_ext : rdata_q;

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    capture   = 1'b0;
    case (state_q)
      DAU_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(ex_type, req_off)) begin
            done     = 1'b1;
            misalign = 1'b1;
          end else if (req_we == DRAM_WRITE && is_word(ex_type)) begin
            mem_addr  = req_idx;
            mem_we    = 1'b1;
            mem_wdata = wdata;
            done      = 1'b1;
          end else begin
            mem_addr = req_idx;
            stall    = 1'b1;
            capture  = 1'b1;
            state_d  = (req_we == DRAM_READ) ? DAU_LOAD_WAIT : DAU_RMW_MERGE;
          end
        end
      end
      DAU_LOAD_WAIT: begin
        mem_addr = idx_q;
        done     = 1'b1;
        state_d  = DAU_IDLE;
      end
      DAU_RMW_MERGE: begin
        mem_addr  = idx_q;
        mem_we    = 1'b1;
        mem_wdata = merged;
        done      = 1'b1;
        state_d   = DAU_IDLE;
      end
      default: state_d = DAU_IDLE;
    endcase
  end

endmodule
